// File: rtl/result_drain_ctrl_if.sv
// rtl/result_drain_ctrl_if.sv - control, buffer-read and packed-output signals of result_drain_ctrl
interface result_drain_ctrl_if #(
  parameter int PACK  = 4,
  parameter int LEN_W = 15
);
  logic                 i_tile_start;
  logic [LEN_W-1:0]     i_tile_len;
  logic                 o_busy;
  logic                 o_start_err;
  logic                 o_buf_rd_en;
  logic [15:0]          i_buf_rd_data;
  logic                 i_buf_empty;
  logic [16*PACK-1:0]   o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_last;
  logic [PACK-1:0]      o_keep;
  logic                 o_tile_done;
  logic [31:0]          o_stall_cycles;
  logic [31:0]          o_underrun_cycles;

  modport slave (
    input  i_tile_start, i_tile_len, i_buf_rd_data, i_buf_empty, i_ready,
    output o_busy, o_start_err, o_buf_rd_en, o_data, o_valid, o_last, o_keep,
           o_tile_done, o_stall_cycles, o_underrun_cycles
  );

  modport master (
    output i_tile_start, i_tile_len, i_buf_rd_data, i_buf_empty, i_ready,
    input  o_busy, o_start_err, o_buf_rd_en, o_data, o_valid, o_last, o_keep,
           o_tile_done, o_stall_cycles, o_underrun_cycles
  );
endinterface

// File: rtl/result_drain_ctrl.sv
// rtl/result_drain_ctrl.sv - drains one FP16 result tile from the result buffer into PACK-lane words
// Optional statistics counters are built when RESULT_DRAIN_STATS_EN is defined.
module result_drain_ctrl #(
  parameter int PACK  = 4,
  parameter int LEN_W = 15
) (
  input  logic               i_clk,
  input  logic               i_reset,
  result_drain_ctrl_if.slave bus
);
  localparam int CW = $clog2(PACK + 1);
  localparam int DW = 16 * PACK;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   issue_rem_q, issue_rem_d;
  logic [CW-1:0]      lanes_q, lanes_d;
  logic               inflight_q, inflight_d;
  logic               last_inflight_q, last_inflight_d;
  logic               asm_last_q, asm_last_d;
  logic [DW-1:0]      asm_q, asm_d;
  logic [DW-1:0]      data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [PACK-1:0]    keep_q, keep_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic               rd_en, start_ok, accept, can_xfer;
  logic               final_arr, complete_now, pending;
  logic [CW:0]        occ;
  logic [CW-1:0]      new_lanes;
  logic [DW-1:0]      merged;

  function automatic logic [PACK-1:0] keep_for(input logic [CW-1:0] n);
    logic [PACK-1:0] m;
    for (int k = 0; k < PACK; k++) m[k] = (CW'(k) < n);
    return m;
  endfunction

  assign occ       = {1'b0, lanes_q} + {{CW{1'b0}}, inflight_q};
  assign rd_en     = (state_q == S_RUN) && !bus.i_buf_empty && (issue_rem_q != '0)
                     && (occ < (CW+1)'(PACK));
  assign start_ok  = (state_q == S_IDLE) && bus.i_tile_start;
  assign accept    = valid_q && bus.i_ready;
  assign can_xfer  = !valid_q || bus.i_ready;
  assign new_lanes = lanes_q + CW'(1);
  assign final_arr = inflight_q && last_inflight_q;
  assign complete_now = inflight_q && ((new_lanes == CW'(PACK)) || final_arr);
  // A finished word may be parked in assembly while the output register is blocked.
  assign pending   = (lanes_q == CW'(PACK)) || asm_last_q;

  always_comb begin
    merged = asm_q;
    for (int k = 0; k < PACK; k++) begin
      if (lanes_q == CW'(k)) merged[16*k +: 16] = bus.i_buf_rd_data;
    end
  end

  always_comb begin
    state_d         = state_q;
    issue_rem_d     = issue_rem_q;
    err_d           = err_q;
    inflight_d      = rd_en;
    last_inflight_d = rd_en && (issue_rem_q == LEN_W'(1));
    if (rd_en) issue_rem_d = issue_rem_q - LEN_W'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.i_tile_start) begin
          issue_rem_d = bus.i_tile_len;
          state_d     = (bus.i_tile_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (rd_en && (issue_rem_q == LEN_W'(1))) state_d = S_DRAIN;
      S_DRAIN: if (accept && last_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (bus.i_tile_start && (state_q != S_IDLE)) err_d = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);

    asm_d      = asm_q;
    lanes_d    = lanes_q;
    asm_last_d = asm_last_q;
    data_d     = data_q;
    last_d     = last_q;
    keep_d     = keep_q;
    valid_d    = valid_q && !bus.i_ready;

    if (complete_now && can_xfer) begin
      // Completing element goes straight to the output, bypassing assembly.
      data_d     = merged;
      valid_d    = 1'b1;
      last_d     = final_arr;
      keep_d     = keep_for(new_lanes);
      asm_d      = '0;
      lanes_d    = '0;
      asm_last_d = 1'b0;
    end else if (complete_now) begin
      asm_d      = merged;
      lanes_d    = new_lanes;
      asm_last_d = final_arr;
    end else if (pending && can_xfer) begin
      data_d     = asm_q;
      valid_d    = 1'b1;
      last_d     = asm_last_q;
      keep_d     = keep_for(lanes_q);
      asm_d      = '0;
      lanes_d    = '0;
      asm_last_d = 1'b0;
    end else if (inflight_q) begin
      asm_d   = merged;
      lanes_d = new_lanes;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q         <= S_IDLE;
      issue_rem_q     <= '0;
      lanes_q         <= '0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
      asm_last_q      <= 1'b0;
      asm_q           <= '0;
      data_q          <= '0;
      valid_q         <= 1'b0;
      last_q          <= 1'b0;
      keep_q          <= '0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      issue_rem_q     <= issue_rem_d;
      lanes_q         <= lanes_d;
      inflight_q      <= inflight_d;
      last_inflight_q <= last_inflight_d;
      asm_last_q      <= asm_last_d;
      asm_q           <= asm_d;
      data_q          <= data_d;
      valid_q         <= valid_d;
      last_q          <= last_d;
      keep_q          <= keep_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
      done_q          <= done_d;
    end
  end

  assign bus.o_buf_rd_en = rd_en;
  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_last      = last_q;
  assign bus.o_keep      = keep_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_start_err = err_q;
  assign bus.o_tile_done = done_q;

`ifdef RESULT_DRAIN_STATS_EN
  logic [31:0] stall_q, stall_d, under_q, under_d;

  always_comb begin
    stall_d = stall_q;
    under_d = under_q;
    if (start_ok) begin
      stall_d = '0;
      under_d = '0;
    end else begin
      if (valid_q && !bus.i_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
      if ((state_q == S_RUN) && bus.i_buf_empty && (issue_rem_q != '0) && (under_q != '1))
        under_d = under_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_q <= '0;
      under_q <= '0;
    end else begin
      stall_q <= stall_d;
      under_q <= under_d;
    end
  end

  assign bus.o_stall_cycles    = stall_q;
  assign bus.o_underrun_cycles = under_q;
`else
  assign bus.o_stall_cycles    = '0;
  assign bus.o_underrun_cycles = '0;
`endif
endmodule

// File: tb/tb_result_drain_ctrl.sv
// tb/tb_result_drain_ctrl.sv - scoreboard bench for result_drain_ctrl with a registered-read buffer model
module tb_result_drain_ctrl;
  localparam int PACK  = 4;
  localparam int LEN_W = 15;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [3:0]  keep;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_drain_ctrl_if #(.PACK(PACK), .LEN_W(LEN_W)) bus ();
  result_drain_ctrl #(.PACK(PACK), .LEN_W(LEN_W)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  int tests = 0, fails = 0;
  word_t exp_q[$];
  logic [15:0] buf_q[$];
  logic gap = 1'b0;
  int cyc = 0, start_cyc = 0, first_rd_cyc = -1, done_cyc = 0, done_cnt = 0, rd_cnt = 0, acc_total = 0;
  int acc_cyc[$];
  logic stall_prev = 1'b0, done_due = 1'b0;
  logic [63:0] hold_data;
  logic hold_last;
  logic [3:0] hold_keep;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Result buffer: registered read, empty flag refreshed mid-cycle.
  always @(posedge clk) begin
    if (bus.o_buf_rd_en) begin
      check("rd_not_empty", bus.i_buf_empty, 0);
      if (buf_q.size() != 0) bus.i_buf_rd_data <= buf_q.pop_front();
      rd_cnt++;
    end
  end

  always @(negedge clk) begin
    #1;
    bus.i_buf_empty = (buf_q.size() == 0) || gap;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      stall_prev = 1'b0;
      done_due   = 1'b0;
    end else begin
      if (bus.i_tile_start && !bus.o_busy) begin
        start_cyc    = cyc;
        first_rd_cyc = -1;
        acc_cyc.delete();
      end
      if (bus.o_buf_rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (done_due) check("tile_done_after_last", bus.o_tile_done, 1);
      if (bus.o_tile_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stall_prev) begin
        check("hold_valid", bus.o_valid, 1);
        check("hold_data", bus.o_data, hold_data);
        check("hold_last", bus.o_last, hold_last);
        check("hold_keep", bus.o_keep, hold_keep);
      end
      done_due = 1'b0;
      if (bus.o_valid && bus.i_ready) begin
        word_t e;
        acc_cyc.push_back(cyc);
        acc_total++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_word: got %h with no word expected", bus.o_data);
        end else begin
          e = exp_q.pop_front();
          tests--;
          check("word_data", bus.o_data, e.data);
          check("word_last", bus.o_last, e.last);
          check("word_keep", bus.o_keep, e.keep);
        end
        done_due = bus.o_last;
      end
      stall_prev = bus.o_valid && !bus.i_ready;
      hold_data  = bus.o_data;
      hold_last  = bus.o_last;
      hold_keep  = bus.o_keep;
    end
  end

  task automatic load(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) buf_q.push_back(base + 16'(i));
  endtask

  task automatic push_exp(input logic [63:0] d, input logic l, input logic [3:0] k);
    word_t w;
    w.data = d; w.last = l; w.keep = k;
    exp_q.push_back(w);
  endtask

  task automatic start_tile(input int len);
    bus.i_tile_start = 1'b1;
    bus.i_tile_len   = LEN_W'(len);
    @(negedge clk);
    bus.i_tile_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c0 = done_cnt;
    int n = 0;
    while (done_cnt == c0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done_cnt == c0) begin
      fails++;
      $display("FAIL %s_timeout: no tile_done after %0d cycles", name, n);
    end
    check({name, "_all_words"}, exp_q.size(), 0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_valid"}, bus.o_valid, 0);
    check({name, "_busy"}, bus.o_busy, 0);
    check({name, "_rd_en"}, bus.o_buf_rd_en, 0);
    check({name, "_last"}, bus.o_last, 0);
    check({name, "_keep"}, bus.o_keep, 0);
    check({name, "_data"}, bus.o_data, 0);
    check({name, "_done"}, bus.o_tile_done, 0);
  endtask

  initial begin
    int r0, a0, d0;
    rst = 1'b1;
    bus.i_tile_start = 1'b0;
    bus.i_tile_len   = '0;
    bus.i_ready      = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check_quiet("reset");
    check("reset_err", bus.o_start_err, 0);
    check("reset_stall", bus.o_stall_cycles, 0);
    check("reset_under", bus.o_underrun_cycles, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // len=8, continuous ready
    load(16'h3C00, 8);
    push_exp(64'h3C03_3C02_3C01_3C00, 1'b0, 4'hF);
    push_exp(64'h3C07_3C06_3C05_3C04, 1'b1, 4'hF);
    @(negedge clk);
    r0 = rd_cnt;
    start_tile(8);
    wait_done("t1");
    check("t1_first_rd", first_rd_cyc - start_cyc, 1);
    check("t1_words", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) begin
      check("t1_first_valid", acc_cyc[0] - start_cyc, 6);
      check("t1_second_valid", acc_cyc[1] - start_cyc, 11);
    end
    check("t1_done_cyc", done_cyc - start_cyc, 12);
    check("t1_reads", rd_cnt - r0, 8);

    // len=6: partial final word
    load(16'h4000, 6);
    push_exp(64'h4003_4002_4001_4000, 1'b0, 4'hF);
    push_exp(64'h0000_0000_4005_4004, 1'b1, 4'h3);
    @(negedge clk);
    start_tile(6);
    wait_done("t2");

    // len=0: no reads, no words, done next cycle
    load(16'h1111, 2);
    @(negedge clk);
    r0 = rd_cnt;
    a0 = acc_total;
    start_tile(0);
    wait_done("t3");
    check("t3_done_cyc", done_cyc - start_cyc, 1);
    check("t3_reads", rd_cnt - r0, 0);
    check("t3_words", acc_total - a0, 0);
    buf_q.delete();
    @(negedge clk);

    // back-pressure: ready low for cycles N+6..N+15
    load(16'h5000, 12);
    push_exp(64'h5003_5002_5001_5000, 1'b0, 4'hF);
    push_exp(64'h5007_5006_5005_5004, 1'b0, 4'hF);
    push_exp(64'h500B_500A_5009_5008, 1'b1, 4'hF);
    @(negedge clk);
    r0 = rd_cnt;
    bus.i_ready = 1'b0;
    start_tile(12);
    repeat (14) @(negedge clk);
    check("t4_reads_stopped", rd_cnt - r0, 8);
    check("t4_valid_held", bus.o_valid, 1);
    @(negedge clk);
    bus.i_ready = 1'b1;
    wait_done("t4");
    check("t4_reads", rd_cnt - r0, 12);
`ifdef RESULT_DRAIN_STATS_EN
    check("t4_stall_cycles", bus.o_stall_cycles, 10);
`else
    check("t4_stall_tied", bus.o_stall_cycles, 0);
`endif

    // buffer empty for cycles N+2..N+6
    load(16'h2000, 8);
    push_exp(64'h2003_2002_2001_2000, 1'b0, 4'hF);
    push_exp(64'h2007_2006_2005_2004, 1'b1, 4'hF);
    @(negedge clk);
    r0 = rd_cnt;
    start_tile(8);
    @(negedge clk);
    gap = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_reads_in_gap", rd_cnt - r0, 1);
    gap = 1'b0;
    wait_done("t5");
`ifdef RESULT_DRAIN_STATS_EN
    check("t5_underrun_cycles", bus.o_underrun_cycles, 5);
`else
    check("t5_underrun_tied", bus.o_underrun_cycles, 0);
`endif

    // reset with a read in flight, then a fresh len=4 tile
    load(16'h6000, 8);
    @(negedge clk);
    start_tile(8);
    @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    #3;
    check_quiet("midrst");
    repeat (2) @(negedge clk);
    buf_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_no_done_on_abort", done_cnt - d0, 0);
    load(16'h7000, 4);
    push_exp(64'h7003_7002_7001_7000, 1'b1, 4'hF);
    r0 = rd_cnt;
    a0 = acc_total;
    @(negedge clk);
    start_tile(4);
    wait_done("t6");
    check("t6_reads", rd_cnt - r0, 4);
    check("t6_words", acc_total - a0, 1);

    // start while busy
    check("t7_err_before", bus.o_start_err, 0);
    load(16'h8000, 4);
    push_exp(64'h8003_8002_8001_8000, 1'b1, 4'hF);
    @(negedge clk);
    start_tile(4);
    bus.i_tile_start = 1'b1;
    bus.i_tile_len   = LEN_W'(7);
    @(negedge clk);
    bus.i_tile_start = 1'b0;
    wait_done("t7");
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    check("t7_err_set", bus.o_start_err, 1);
    check("t7_no_extra_tile", done_cnt - d0, 0);
    check("t7_idle", bus.o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
